ci_bin_to_bcd: RTL and testbench

CI_BIN_TO_BCD -- requirements
Module: ci_bin_to_bcd

---
 rtl/bcd_pkg.sv | 38 +++
 rtl/bcd_add3.sv | 24 ++
 rtl/ci_bin_to_bcd.sv | 182 ++++++++++++++++++
 tb/tb_ci_bin_to_bcd.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared definitions for the binary-to-BCD custom instruction:
//               FSM state type and encodings, default operand width and
//               digit count, result flag bit positions, and a constant
//               power-of-ten helper used for the overflow limit.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Default operand width and digit count (six HEX displays).
    localparam int c_default_in_width = 20;
    localparam int c_default_digits   = 6;

    // Flag positions inside the 32-bit result word.
    localparam int c_ovf_bit  = 24;
    localparam int c_sign_bit = 25;

    // Conversion FSM state type and encodings.
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_shift = 2'd1;
    localparam state_t c_st_fin   = 2'd2;

    // 10**n evaluated at elaboration time; 64 bits leaves headroom for any
    // digit count that fits below the flag bits of the result word.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Combinational single-digit double-dabble correction. A digit
//               of 5 or more gets 3 added so that the following left shift
//               carries correctly into the next decimal digit.
// Ports       : i_digit [3:0]  BCD digit before correction
//               o_digit [3:0]  corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule : bcd_add3
`default_nettype wire

// File: rtl/ci_bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : ci_bin_to_bcd
// Description : Nios II multi-cycle custom instruction converting a binary
//               operand to packed BCD with the shift-and-add-3 algorithm,
//               one bit per enabled clock. Operands of 10**DIGITS or more
//               saturate to all nines and raise the overflow flag.
//               Optional feature macro: BCD_SIGNED_EN (signed operand,
//               magnitude converted, sign flag reported).
// Ports       : clk     in   clock, rising edge
//               reset   in   synchronous active-high reset
//               clk_en  in   custom-instruction clock enable
//               start   in   conversion request (qualified by clk_en)
//               dataa   in   [31:0] operand
//               result  out  [31:0] BCD digits [4*DIGITS-1:0], overflow
//                            flag [24], sign flag [25], other bits zero
//               done    out  single-cycle completion strobe
// Revision    : 1.0 - initial release
// ============================================================================
module ci_bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = c_default_in_width,
    parameter int DIGITS   = c_default_digits
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done
);

    localparam int c_cnt_w = $clog2(IN_WIDTH + 1);
    localparam int c_bcd_w = 4 * DIGITS;

    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(IN_WIDTH);
    localparam logic [63:0]        c_limit    = pow10(DIGITS);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [IN_WIDTH-1:0]  r_bin;
    logic [c_bcd_w-1:0]   r_bcd;
    logic                 r_ovf;
    logic                 r_sign;
    logic [31:0]          r_result;

    logic [31:0]          w_mag32;
    logic                 w_sign_in;
    logic [IN_WIDTH-1:0]  w_operand;
    logic [63:0]          w_operand64;
    logic                 w_ovf_in;
    logic [c_bcd_w-1:0]   w_bcd_adj;
    logic [c_bcd_w-1:0]   w_bcd_shifted;
    logic [31:0]          w_result_fin;
    logic                 w_last;
    logic                 w_unused;

    // ------------------------------------------------------------------
    // Operand conditioning at capture time
    // ------------------------------------------------------------------
`ifdef BCD_SIGNED_EN
    // Two's complement magnitude of the full 32-bit word, then truncated.
    assign w_sign_in = dataa[31];
    assign w_mag32   = dataa[31] ? (~dataa + 32'd1) : dataa;
`else
    assign w_sign_in = 1'b0;
    assign w_mag32   = dataa;
`endif

    assign w_operand = w_mag32[IN_WIDTH-1:0];

    always_comb begin
        w_operand64                 = '0;
        w_operand64[IN_WIDTH-1:0]   = w_operand;
    end

    // Overflow is decided once from the captured operand; the accumulator
    // only holds DIGITS digits and may wrap, but its value is then replaced
    // by all nines when the result is formed.
    assign w_ovf_in = (w_operand64 >= c_limit);

    // ------------------------------------------------------------------
    // Per-digit add-3 correction ahead of the shift
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_add3 u_add3 (
            .i_digit (r_bcd[4*gi +: 4]),
            .o_digit (w_bcd_adj[4*gi +: 4])
        );
    end

    // {bcd, operand} shifted left one place.
    assign w_bcd_shifted = {w_bcd_adj[c_bcd_w-2:0], r_bin[IN_WIDTH-1]};

    assign w_last = (r_state == c_st_shift) && (r_cnt == c_cnt_one);

    // Final result word built from the last shift step so that the
    // registered result is already valid in the cycle done is asserted.
    always_comb begin
        w_result_fin = '0;
        w_result_fin[c_bcd_w-1:0] = r_ovf ? {DIGITS{4'h9}} : w_bcd_shifted;
        w_result_fin[c_ovf_bit]   = r_ovf;
        w_result_fin[c_sign_bit]  = r_sign;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A qualified start restarts from any state, which
    // covers both the normal launch and the abort of a running conversion.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (clk_en) begin
            if (start) begin
                w_state_next = c_st_shift;
            end else begin
                case (r_state)
                    c_st_idle:  w_state_next = c_st_idle;
                    c_st_shift: begin
                        if (r_cnt == c_cnt_one) begin
                            w_state_next = c_st_fin;
                        end
                    end
                    c_st_fin:   w_state_next = c_st_idle;
                    default:    w_state_next = c_st_idle;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifter, BCD accumulator, counter, result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
            r_sign   <= 1'b0;
            r_result <= '0;
        end else if (clk_en) begin
            if (start) begin
                r_bin  <= w_operand;
                r_bcd  <= '0;
                r_cnt  <= c_cnt_load;
                r_ovf  <= w_ovf_in;
                r_sign <= w_sign_in;
            end else if (r_state == c_st_shift) begin
                r_bcd <= w_bcd_shifted;
                r_bin <= {r_bin[IN_WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt - c_cnt_one;
                if (w_last) begin
                    r_result <= w_result_fin;
                end
            end
        end
    end

    assign result = r_result;
    assign done   = (r_state == c_st_fin) && clk_en;

    // Operand bits above IN_WIDTH and the digit carried out of the top of
    // the accumulator are intentionally discarded.
    assign w_unused = &{1'b0, w_mag32, w_bcd_adj[c_bcd_w-1]};

endmodule : ci_bin_to_bcd
`default_nettype wire

// File: tb/tb_ci_bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_ci_bin_to_bcd
// Description : Directed self-checking bench for ci_bin_to_bcd with default
//               parameters (IN_WIDTH=20, DIGITS=6). Expected values are
//               hand-computed constants; BCD_SIGNED_EN selects the signed
//               expectation for the negative operand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ci_bin_to_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ci_bin_to_bcd dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .result (result),
        .done   (done)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start and count cycles until done (bounded).
    task automatic convert(input logic [31:0] val, output int lat, output logic [31:0] res);
        dataa  = val;
        clk_en = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        lat    = 1;
        while (done !== 1'b1 && lat < 80) begin
            step();
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        int          lat;
        logic [31:0] res;
        reset  = 1'b1;
        clk_en = 1'b0;
        start  = 1'b1;
        dataa  = 32'd5;
        repeat (3) step();
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected %h", result, 32'h0);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        reset = 1'b0;
        start = 1'b0;
        // First start straight after reset deasserts must be accepted.
        convert(32'd7, lat, res);
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL first_start_latency: got %0d expected 21", lat);
        end
        checks++;
        if (res !== 32'h00000007) begin
            errors++;
            $display("FAIL first_start_result: got %h expected %h", res, 32'h00000007);
        end
        step();
    endtask

    task automatic test_vectors();
        logic [31:0] vin [8];
        logic [31:0] vexp[8];
        int          lat;
        logic [31:0] res;
        vin[0] = 32'd123456;  vexp[0] = 32'h00123456;
        vin[1] = 32'd0;       vexp[1] = 32'h00000000;
        vin[2] = 32'd7;       vexp[2] = 32'h00000007;
        vin[3] = 32'd999999;  vexp[3] = 32'h00999999;
        vin[4] = 32'd1000000; vexp[4] = 32'h01999999;
        vin[5] = 32'd1048575; vexp[5] = 32'h01999999;
        vin[6] = 32'd100000;  vexp[6] = 32'h00100000;
        vin[7] = 32'd42;      vexp[7] = 32'h00000042;
        for (int i = 0; i < 8; i++) begin
            convert(vin[i], lat, res);
            checks++;
            if (lat !== 21) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d expected 21", i, lat);
            end
            checks++;
            if (res !== vexp[i]) begin
                errors++;
                $display("FAIL vec%0d_result: got %h expected %h", i, res, vexp[i]);
            end
            step();
            checks++;
            if (done !== 1'b0 || result !== vexp[i]) begin
                errors++;
                $display("FAIL vec%0d_hold: done %b result %h expected done 0 result %h",
                         i, done, result, vexp[i]);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        int bad;
        // Previous conversion left 0x42 in result.
        dataa  = 32'd314159;
        clk_en = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        lat    = 1;
        while (lat < 5) begin
            step();
            lat++;
        end
        clk_en = 1'b0;
        bad    = 0;
        repeat (5) begin
            step();
            lat++;
            if (done !== 1'b0 || result !== 32'h00000042) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_frozen: got %0d bad cycles expected 0", bad);
        end
        clk_en = 1'b1;
        while (done !== 1'b1 && lat < 80) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== 26) begin
            errors++;
            $display("FAIL stall_latency: got %0d expected 26", lat);
        end
        checks++;
        if (result !== 32'h00314159) begin
            errors++;
            $display("FAIL stall_result: got %h expected %h", result, 32'h00314159);
        end
        step();
    endtask

    task automatic test_reset_midway();
        int          lat;
        int          seen;
        logic [31:0] res;
        dataa  = 32'd123456;
        clk_en = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        seen  = 0;
        repeat (30) begin
            if (done === 1'b1) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d done cycles expected 0", seen);
        end
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL midreset_result: got %h expected %h", result, 32'h0);
        end
        convert(32'd42, lat, res);
        checks++;
        if (lat !== 21 || res !== 32'h00000042) begin
            errors++;
            $display("FAIL midreset_next: latency %0d result %h expected 21 %h",
                     lat, res, 32'h00000042);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          seen;
        logic [31:0] res;
        // Abort: restart with a new operand five cycles into a conversion.
        dataa  = 32'd111;
        clk_en = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        seen   = 0;
        repeat (5) begin
            if (done === 1'b1) seen++;
            step();
        end
        convert(32'd222, lat, res);
        checks++;
        if (lat !== 21 || seen != 0) begin
            errors++;
            $display("FAIL abort_latency: latency %0d early done %0d expected 21 0", lat, seen);
        end
        checks++;
        if (res !== 32'h00000222) begin
            errors++;
            $display("FAIL abort_result: got %h expected %h", res, 32'h00000222);
        end
        step();
        // Reset wins over a coincident start.
        reset = 1'b1;
        start = 1'b1;
        dataa = 32'd999;
        step();
        reset = 1'b0;
        start = 1'b0;
        seen  = 0;
        repeat (25) begin
            if (done === 1'b1) seen++;
            step();
        end
        checks++;
        if (seen != 0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_vs_start: done cycles %0d result %h expected 0 %h",
                     seen, result, 32'h0);
        end
    endtask

    task automatic test_signed();
        int          lat;
        logic [31:0] res;
        logic [31:0] exp_res;
`ifdef BCD_SIGNED_EN
        exp_res = 32'h02000042;
`else
        // 0xFFFFFFD6 truncated to 20 bits is 1048534, which overflows.
        exp_res = 32'h01999999;
`endif
        convert(32'hFFFFFFD6, lat, res);
        checks++;
        if (lat !== 21 || res !== exp_res) begin
            errors++;
            $display("FAIL negative_operand: latency %0d result %h expected 21 %h",
                     lat, res, exp_res);
        end
        step();
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b0;
        start  = 1'b0;
        dataa  = '0;
        test_reset();
        test_vectors();
        test_stall();
        test_reset_midway();
        test_back_to_back();
        test_signed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ci_bin_to_bcd
`default_nettype wire
